// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - state encoding and 16x oversampling constants shared by the UART transmitter and receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int OS_MID     = 7;
  localparam int OS_LAST    = 15;

  // XOR of the low nbits of w; bits at or above nbits do not contribute
  function automatic logic word_parity(input logic [7:0] w, input int nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ w[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, DBIT data bits LSB first, stop, paced by the 16x s_tick
// Defining UART_TX_PARITY_EN inserts a parity bit (even, or odd with PARITY_ODD=1) before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [4:0] S_LAST  = 5'(OS_LAST);
  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  if (DBIT < 5 || DBIT > 8 || SB_TICK < 16 || SB_TICK > 32 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx: illegal DBIT/SB_TICK/PARITY_ODD");
  end

  uart_state_e state_q, state_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  localparam uart_state_e DATA_EXIT = PARITY;
`else
  localparam uart_state_e DATA_EXIT = STOP;
`endif

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        // s_tick is deliberately ignored here so START always spans 16 full ticks
        if (tx_start) begin
          b_d     = din;
          s_d     = 5'd0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = word_parity(din, DBIT) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = 5'd0;
            n_d     = 3'd0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = 5'd0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) state_d = DATA_EXIT;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = 5'd0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            state_d      = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so the pin register changes on the same edge as state
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= 5'd0;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx with DBIT=8, SB_TICK=16 and s_tick every 4 clk
module tb_uart_tx;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * 16;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       s_tick   = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din      = 8'h00;
  logic       tx_done_tick;
  logic       tx_busy;
  logic       tx;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  int tick_div = 0;

  uart_tx #(
    .DBIT      (DBIT),
    .SB_TICK   (SB_TICK),
    .PARITY_ODD(0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .tx_start    (tx_start),
    .din         (din),
    .tx_done_tick(tx_done_tick),
    .tx_busy     (tx_busy),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    tick_div = (tick_div + 1) % 4;
    s_tick   = (tick_div == 0);
  end

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    @(posedge clk);
    #2 din = d;
    tx_start = 1'b1;
    @(posedge clk);
    #2 tx_start = 1'b0;
  endtask

  // Called after the accepting edge; walks the frame tick by tick, sampling each bit mid-period
  task automatic check_frame(input string tag, input logic [7:0] d, input bit inject);
    logic [10:0] f;
    int  t;
    bit  seen;
    bit  inj;
    bit  busy_ok;
    f       = frame_bits(d);
    t       = 0;
    seen    = 1'b0;
    inj     = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk);
    check({tag, ".start_low"}, tx, 0);
    check({tag, ".busy_on"}, tx_busy, 1);
    for (int cyc = 0; cyc < FRAME * 4 + 40; cyc++) begin
      if (inject && inj && tx_start) tx_start = 1'b0;
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
      if (s_tick) begin
        if ((t % 16) == 8 && (t / 16) < NBITS)
          check($sformatf("%s.bit%0d", tag, t / 16), tx, f[t / 16]);
        if (tx_done_tick) begin
          check({tag, ".done_at_tick"}, t, FRAME - 1);
          seen = 1'b1;
        end
        t++;
      end
      if (seen) break;
      if (inject && !inj && t == 70) begin
        tx_start = 1'b1;
        din      = 8'hFF;
        inj      = 1'b1;
      end
      @(negedge clk);
    end
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".busy_through"}, busy_ok, 1);
  endtask

  task automatic check_idle_after(input string tag, input int d0);
    @(negedge clk);
    check({tag, ".idle_tx"}, tx, 1);
    check({tag, ".idle_busy"}, tx_busy, 0);
    check({tag, ".one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    int  t;
    bit  idle_ok;

    repeat (3) @(negedge clk);
    check("reset.tx", tx, 1);
    check("reset.busy", tx_busy, 0);
    check("reset.done", tx_done_tick, 0);
    reset = 1'b0;

    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
    end
    check("idle.level", idle_ok, 1);
    check("idle.no_done", done_cnt, 0);

    d0 = done_cnt;
    start_frame(8'hA5);
    check_frame("a5", 8'hA5, 1'b0);
    check_idle_after("a5", d0);

    d0 = done_cnt;
    start_frame(8'h3C);
    check_frame("3c_ignore_ff", 8'h3C, 1'b1);
    check_idle_after("3c_ignore_ff", d0);
    repeat (8) @(negedge clk);
    check("3c_ignore_ff.still_idle", tx_busy, 0);

    d0 = done_cnt;
    @(posedge clk);
    #2 din = 8'h5A;
    tx_start = 1'b1;
    @(posedge clk);
    check_frame("hold1", 8'h5A, 1'b0);
    check_idle_after("hold1", d0);
    din = 8'hC3;
    @(posedge clk);
    check_frame("hold2", 8'hC3, 1'b0);
    tx_start = 1'b0;
    check_idle_after("hold2", d0 + 1);

    d0 = done_cnt;
    start_frame(8'hA5);
    t = 0;
    for (int cyc = 0; cyc < 400 && t < 68; cyc++) begin
      @(negedge clk);
      if (s_tick) t++;
    end
    check("rst_mid.reached_bit3", t, 68);
    check("rst_mid.tx_low_before", tx, 0);
    reset = 1'b1;
    #1;
    check("rst_mid.tx_high", tx, 1);
    check("rst_mid.busy_low", tx_busy, 0);
    check("rst_mid.no_done_tick", tx_done_tick, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_mid.no_done_count", done_cnt - d0, 0);

    d0 = done_cnt;
    start_frame(8'h96);
    check_frame("after_rst", 8'h96, 1'b0);
    check_idle_after("after_rst", d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
